trax_board_scanner: RTL and testbench

Sequential, parametrised successor to the single-cell Trax tile checker. It holds a ROWS×COLS board of 3-bit tile codes and, on start, scans every cell in row-major order. For each empty cell it computes the legal-tile mask from its four neighbours and streams reportable cells out over a valid/ready handshake. It sits between the board-update logic and the move generator/AI.

---
 rtl/trax_board_scanner_if.sv | 18 +
 rtl/trax_board_scanner.sv | 213 +++++++++++++++++++++
 tb/tb_trax_board_scanner.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/trax_board_scanner_if.sv
// Report stream of trax_board_scanner: valid/ready handshake carrying cell
// coordinates, legal-tile mask and forced flag.
interface trax_board_scanner_if #(
  parameter int unsigned RW = 3,
  parameter int unsigned CW = 3
);
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic [5:0]    out_mask;
  logic          out_forced;

  modport master (output out_valid, out_row, out_col, out_mask, out_forced,
                  input  out_ready);
  modport slave  (input  out_valid, out_row, out_col, out_mask, out_forced,
                  output out_ready);
endinterface

// File: rtl/trax_board_scanner.sv
// Row-major Trax board scanner: per empty cell, legal-tile mask from the four
// neighbours, streamed out over valid/ready. `TILE_CONFLICT_EN reports conflict cells.
module trax_board_scanner #(
  parameter int unsigned  ROWS       = 8,
  parameter int unsigned  COLS       = 8,
  parameter int unsigned  IDX_W      = 6,
  parameter bit           REPORT_ALL = 1'b0,
  localparam int unsigned RW         = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW         = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [RW-1:0]        wr_row,
  input  logic [CW-1:0]        wr_col,
  input  logic [2:0]           wr_tile,
  input  logic                 start_signal,
  output logic                 busy,
  trax_board_scanner_if.master out_if,
  output logic                 conflict,
  output logic [IDX_W:0]       forced_count,
  output logic                 endsignal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // White edges of a tile as {down, right, up, left}.
  function automatic logic [3:0] white_edges(input logic [2:0] t);
    case (t)
      3'd1:    white_edges = 4'b1100;
      3'd2:    white_edges = 4'b0011;
      3'd3:    white_edges = 4'b1010;
      3'd4:    white_edges = 4'b0101;
      3'd5:    white_edges = 4'b0110;
      3'd6:    white_edges = 4'b1001;
      default: white_edges = 4'b0000;
    endcase
  endfunction

  function automatic logic is_tile(input logic [2:0] t);
    is_tile = (t != 3'd0) && (t != 3'd7);
  endfunction

  logic [2:0]     board_q [ROWS][COLS];
  logic [1:0]     state_q, state_d;
  logic [RW-1:0]  row_q, row_d, orow_q, orow_d;
  logic [CW-1:0]  col_q, col_d, ocol_q, ocol_d;
  logic           valid_q, valid_d, oforced_q, oforced_d;
  logic [5:0]     omask_q, omask_d;
  logic [IDX_W:0] fcnt_q, fcnt_d;

  logic [2:0]     cur_t, left_t, up_t, right_t, down_t;
  logic [3:0]     w, wl, wu, wr, wd;
  logic [5:0]     mask;
  logic [2:0]     pop;
  logic           last_col, last_cell, candidate, cell_forced, report_conflict, reportable;
  logic [RW-1:0]  adv_row;
  logic [CW-1:0]  adv_col;

  assign last_col  = (col_q == CW'(COLS - 1));
  assign last_cell = last_col && (row_q == RW'(ROWS - 1));
  assign adv_col   = last_col ? '0 : col_q + 1'b1;
  assign adv_row   = last_col ? row_q + 1'b1 : row_q;

  always_comb begin
    cur_t   = board_q[row_q][col_q];
    left_t  = (col_q != '0) ? board_q[row_q][col_q - 1'b1] : 3'd0;
    up_t    = (row_q != '0) ? board_q[row_q - 1'b1][col_q] : 3'd0;
    right_t = last_col ? 3'd0 : board_q[row_q][col_q + 1'b1];
    down_t  = (row_q == RW'(ROWS - 1)) ? 3'd0 : board_q[row_q + 1'b1][col_q];
  end

  // A tile fits when each shared edge has the colour of the neighbour's facing edge.
  always_comb begin
    wl   = white_edges(left_t);
    wu   = white_edges(up_t);
    wr   = white_edges(right_t);
    wd   = white_edges(down_t);
    w    = '0;
    mask = '0;
    pop  = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      w       = white_edges(3'(k + 1));
      mask[k] = (!is_tile(left_t)  || (w[0] == wl[2])) &&
                (!is_tile(up_t)    || (w[1] == wu[3])) &&
                (!is_tile(right_t) || (w[2] == wr[0])) &&
                (!is_tile(down_t)  || (w[3] == wd[1]));
      pop     = pop + {2'b00, mask[k]};
    end
  end

  assign candidate   = !is_tile(cur_t) &&
                       (is_tile(left_t) || is_tile(up_t) || is_tile(right_t) || is_tile(down_t));
  assign cell_forced = candidate && (pop == 3'd1);
  assign reportable  = report_conflict ||
                       (REPORT_ALL ? (candidate && (mask != '0)) : cell_forced);

`ifdef TILE_CONFLICT_EN
  logic conflict_q, conflict_d;

  assign report_conflict = candidate && (mask == '0);
  assign conflict_d = (state_q == S_IDLE && start_signal) ? 1'b0 :
                      (state_q == S_SCAN && report_conflict) ? 1'b1 : conflict_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) conflict_q <= 1'b0;
    else          conflict_q <= conflict_d;
  end

  assign conflict = conflict_q;
`else
  assign report_conflict = 1'b0;
  assign conflict        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    valid_d   = valid_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    omask_d   = omask_q;
    oforced_d = oforced_q;
    fcnt_d    = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_signal) begin
          state_d = S_SCAN;
          row_d   = '0;
          col_d   = '0;
          fcnt_d  = '0;
        end
      end
      S_SCAN: begin
        if (cell_forced && (fcnt_q != '1)) fcnt_d = fcnt_q + 1'b1;
        if (reportable) begin
          valid_d   = 1'b1;
          orow_d    = row_q;
          ocol_d    = col_q;
          omask_d   = mask;
          oforced_d = cell_forced;
          state_d   = S_EMIT;
        end else if (last_cell) begin
          state_d = S_DONE;
        end else begin
          row_d = adv_row;
          col_d = adv_col;
        end
      end
      S_EMIT: begin
        if (out_if.out_ready) begin
          valid_d = 1'b0;
          if (last_cell) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
            row_d   = adv_row;
            col_d   = adv_col;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          board_q[r][c] <= '0;
    end else if (state_q == S_IDLE && wr_en) begin
      board_q[wr_row][wr_col] <= wr_tile;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      valid_q   <= 1'b0;
      orow_q    <= '0;
      ocol_q    <= '0;
      omask_q   <= '0;
      oforced_q <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      valid_q   <= valid_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      omask_q   <= omask_d;
      oforced_q <= oforced_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign busy              = (state_q != S_IDLE);
  assign endsignal         = (state_q == S_DONE);
  assign forced_count      = fcnt_q;
  assign out_if.out_valid  = valid_q;
  assign out_if.out_row    = orow_q;
  assign out_if.out_col    = ocol_q;
  assign out_if.out_mask   = omask_q;
  assign out_if.out_forced = oforced_q;

endmodule

// File: tb/tb_trax_board_scanner.sv
// Directed bench for trax_board_scanner: two instances (REPORT_ALL=0 and 1)
// sharing the write port, hand-computed report lists and cycle counts.
`timescale 1ns/1ps
module tb_trax_board_scanner;

`ifdef TILE_CONFLICT_EN
  localparam logic CONF_EN = 1'b1;
`else
  localparam logic CONF_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n, wr_en, go, sel, rdy;
  logic [2:0] wr_row, wr_col, wr_tile;
  logic       busy0, busy1, conf0, conf1, end0, end1;
  logic [6:0] fc0, fc1;

  trax_board_scanner_if #(.RW(3), .CW(3)) if0 ();
  trax_board_scanner_if #(.RW(3), .CW(3)) if1 ();
  assign if0.out_ready = rdy;
  assign if1.out_ready = rdy;

  trax_board_scanner #(.ROWS(8), .COLS(8), .IDX_W(6), .REPORT_ALL(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_tile(wr_tile), .start_signal(go & ~sel), .busy(busy0), .out_if(if0),
    .conflict(conf0), .forced_count(fc0), .endsignal(end0));

  trax_board_scanner #(.ROWS(8), .COLS(8), .IDX_W(6), .REPORT_ALL(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_tile(wr_tile), .start_signal(go & sel), .busy(busy1), .out_if(if1),
    .conflict(conf1), .forced_count(fc1), .endsignal(end1));

  always #5 clock = ~clock;

  logic        m_valid, m_busy, m_end, m_conf;
  logic [6:0]  m_fc;
  logic [12:0] m_rpt;
  always_comb begin
    if (sel) begin
      m_valid = if1.out_valid; m_busy = busy1; m_end = end1; m_conf = conf1; m_fc = fc1;
      m_rpt   = {if1.out_row, if1.out_col, if1.out_mask, if1.out_forced};
    end else begin
      m_valid = if0.out_valid; m_busy = busy0; m_end = end0; m_conf = conf0; m_fc = fc0;
      m_rpt   = {if0.out_row, if0.out_col, if0.out_mask, if0.out_forced};
    end
  end

  int          n_checks, n_errors, end_k;
  logic        busy_at0, busy_after, conf_at0;
  logic [12:0] got_q[$];
  logic [12:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic ex(input logic [2:0] r, input logic [2:0] c, input logic [5:0] m, input logic f);
    exp_q.push_back({r, c, m, f});
  endtask

  task automatic check_reports(input string tag);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_rpt%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"},   busy0, 0);
    check_eq({tag, "_valid"},  if0.out_valid, 0);
    check_eq({tag, "_rpt"},    {if0.out_row, if0.out_col, if0.out_mask, if0.out_forced}, 0);
    check_eq({tag, "_conf"},   conf0, 0);
    check_eq({tag, "_fc"},     fc0, 0);
    check_eq({tag, "_end"},    end0, 0);
    check_eq({tag, "_dut1"},   {busy1, if1.out_valid, if1.out_row, if1.out_col,
                                if1.out_mask, if1.out_forced, conf1, fc1, end1}, 0);
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic write_cell(input logic [2:0] r, input logic [2:0] c, input logic [2:0] t);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_tile = t;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  // k counts cycles after the start edge; end_k is the k where endsignal is seen.
  // A nonzero stall holds ready low on the first report and tries to overwrite (2,4).
  task automatic run_scan(input logic s, input int stall);
    logic        stalled, stable, done;
    logic [12:0] snap;
    int          k;
    got_q.delete();
    sel = s; stalled = 1'b0; done = 1'b0; end_k = -1; k = 0;
    go = 1'b1;
    @(negedge clock);
    go = 1'b0; wr_en = 1'b0;
    busy_at0 = m_busy; conf_at0 = m_conf;
    while (!done && k < 400) begin
      if (m_valid) begin
        if (stall > 0 && !stalled) begin
          stalled = 1'b1; stable = 1'b1; snap = m_rpt; rdy = 1'b0;
          wr_en = 1'b1; wr_row = 3'd2; wr_col = 3'd4; wr_tile = 3'd5;
          repeat (stall) begin
            @(negedge clock);
            k++;
            wr_en = 1'b0;
            if (!m_valid || m_rpt !== snap || !m_busy) stable = 1'b0;
          end
          check_eq("stall_stable", stable, 1);
          rdy = 1'b1;
        end
        got_q.push_back(m_rpt);
      end
      if (m_end) begin
        end_k = k; done = 1'b1;
      end else begin
        @(negedge clock);
        k++;
      end
    end
    check_eq("scan_end_seen", done, 1);
    @(negedge clock);
    busy_after = m_busy;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_errors = 0;
    reset_n = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_tile = '0;
    go = 1'b0; sel = 1'b0; rdy = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_outputs_zero("por");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Empty board
    run_scan(1'b0, 0);
    check_reports("empty");
    check_eq("empty_end_k", end_k, 64);
    check_eq("empty_busy_at0", busy_at0, 1);
    check_eq("empty_busy_after", busy_after, 0);
    check_eq("empty_fc", fc0, 0);

    // Single plus_hz at (3,3)
    write_cell(3'd3, 3'd3, 3'd4);
    run_scan(1'b1, 0);
    ex(2, 3, 6'h1A, 0); ex(3, 2, 6'h19, 0); ex(3, 4, 6'h2A, 0); ex(4, 3, 6'h29, 0);
    check_reports("all_hz");
    check_eq("all_hz_end_k", end_k, 68);
    check_eq("all_hz_fc", fc1, 0);
    run_scan(1'b0, 0);
    check_reports("forced_hz");
    check_eq("forced_hz_end_k", end_k, 64);

    // Two forced cells; last write lands in the same cycle as start; stalled report
    reset_dut();
    write_cell(3'd3, 3'd3, 3'd4);
    wr_en = 1'b1; wr_row = 3'd2; wr_col = 3'd4; wr_tile = 3'd3;
    run_scan(1'b0, 10);
    ex(2, 3, 6'h02, 1); ex(3, 4, 6'h02, 1);
    check_reports("stall");
    check_eq("stall_end_k", end_k, 76);
    check_eq("stall_fc", fc0, 2);
    run_scan(1'b0, 0);
    ex(2, 3, 6'h02, 1); ex(3, 4, 6'h02, 1);
    check_reports("readback");
    check_eq("readback_end_k", end_k, 66);
    check_eq("readback_fc", fc0, 2);

    // Conflict at (1,1)
    reset_dut();
    write_cell(3'd1, 3'd0, 3'd4);
    write_cell(3'd0, 3'd1, 3'd3);
    write_cell(3'd1, 3'd2, 3'd4);
    run_scan(1'b0, 0);
    ex(0, 0, 6'h02, 1); ex(0, 2, 6'h10, 1);
`ifdef TILE_CONFLICT_EN
    ex(1, 1, 6'h00, 0);
`endif
    check_reports("conf");
    check_eq("conf_end_k", end_k, CONF_EN ? 67 : 66);
    check_eq("conf_fc", fc0, 2);
    check_eq("conf_flag", conf0, CONF_EN);
    run_scan(1'b0, 0);
    got_q.delete();
    check_eq("conf_cleared_on_start", conf_at0, 0);
    check_eq("conf_flag_again", conf0, CONF_EN);
    run_scan(1'b1, 0);
    ex(0, 0, 6'h02, 1); ex(0, 2, 6'h10, 1);
`ifdef TILE_CONFLICT_EN
    ex(1, 1, 6'h00, 0);
`endif
    ex(1, 3, 6'h2A, 0); ex(2, 0, 6'h29, 0); ex(2, 2, 6'h29, 0);
    check_reports("conf_all");
    check_eq("conf_all_fc", fc1, 2);
    check_eq("conf_all_flag", conf1, CONF_EN);

    // Reset while a report is pending
    reset_dut();
    write_cell(3'd3, 3'd3, 3'd4);
    write_cell(3'd2, 3'd4, 3'd3);
    sel = 1'b0; rdy = 1'b0; go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    for (int i = 0; i < 40 && !m_valid; i++) @(negedge clock);
    check_eq("emit_reached", m_valid, 1);
    reset_n = 1'b0;
    #1 check_outputs_zero("emit_reset");
    @(negedge clock);
    reset_n = 1'b1; rdy = 1'b1;
    @(negedge clock);
    run_scan(1'b0, 0);
    check_reports("post_reset");
    check_eq("post_reset_end_k", end_k, 64);
    check_eq("post_reset_fc", fc0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
